// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, turns MEM exceptions into a one-cycle flush, and tracks stall watchdog/perf count
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int          WD_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {S_RUN = 1'b0, S_RECOVER = 1'b1} state_t;

  localparam logic [15:0] WD_MATCH = 16'(WD_LIMIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_exc;
  logic        w_stalled;
  logic [15:0] r_wd_cnt;
  logic        r_timeout;
  logic [31:0] r_stall_cycles;

  // Flush/redirect and stall vector; everything is forced quiet while reset is held
  always_comb begin
    w_exc       = rst && (r_state == S_RUN) && (excepttype_i != 32'd0);
    flush       = w_exc;
    new_pc      = w_exc ? ((excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR) : 32'd0;
    stall       = (!rst || w_exc) ? 6'b000000 :
                  stallreq_mem    ? 6'b011111 :
                  stallreq_ex     ? 6'b001111 :
                  stallreq_id     ? 6'b000111 :
                  stallreq_if     ? 6'b000011 : 6'b000000;
    w_stalled   = stall[0] && !flush;
    w_state_nxt = w_exc ? S_RECOVER : S_RUN;
  end

  // State register: a flush always spends exactly one cycle in RECOVER
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  // Consecutive-stall watchdog with sticky timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_stalled ? ((r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1) : 16'd0;
      if (w_stalled && (r_wd_cnt == WD_MATCH)) r_timeout <= 1'b1;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         r_stall_cycles <= 32'd0;
    else if (stall[0] && r_stall_cycles != 32'hFFFF_FFFF) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign timeout      = r_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = 32'd0, cp0_epc_i = 32'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  bit              m_rec;
  int              m_run;
  bit              m_to;
  longint unsigned m_sc;

  pipe_ctrl #(.WD_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .timeout(timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rec = 0;
    m_run = 0;
    m_to  = 0;
    m_sc  = 0;
  endtask

  // Drive inputs at posedge+1 and let them settle to posedge+3
  task automatic set(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    #2;
  endtask

  // Compare all outputs with the model, then advance one clock and update the model
  task automatic tick(input string tag);
    int   d;
    bit   ef;
    int   e_st;
    logic [31:0] e_pc;
    ef   = !m_rec && (excepttype_i != 0);
    d    = stallreq_mem ? 4 : stallreq_ex ? 3 : stallreq_id ? 2 : stallreq_if ? 1 : 0;
    e_st = (ef || d == 0) ? 0 : (1 << (d + 1)) - 1;
    e_pc = !ef ? 32'd0 : (excepttype_i == 32'h0000_000e) ? cp0_epc_i : 32'h0000_0040;
    chk({tag, ".stall"},   {26'd0, stall}, e_st);
    chk({tag, ".flush"},   {31'd0, flush}, {31'd0, ef});
    chk({tag, ".new_pc"},  new_pc, e_pc);
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_to});
    chk({tag, ".cycles"},  stall_cycles, m_sc[31:0]);
    @(posedge clk);
    if (e_st[0]) begin
      m_run++;
      if (m_run >= 4) m_to = 1;
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
    end else m_run = 0;
    m_rec = ef;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0]  r_req;
    logic [31:0] r_exc;
    model_reset();
    // Reset holds outputs quiet even with active inputs
    stallreq_mem = 1'b1;
    excepttype_i = 32'h8;
    #3;
    chk("rst.stall",  {26'd0, stall}, 32'd0);
    chk("rst.flush",  {31'd0, flush}, 32'd0);
    chk("rst.new_pc", new_pc, 32'd0);
    chk("rst.cycles", stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    // Cumulative priority
    set(4'b0001, 0, 0); chk("prio1", {26'd0, stall}, 32'h03); tick("p1");
    set(4'b0011, 0, 0); chk("prio2", {26'd0, stall}, 32'h07); tick("p2");
    set(4'b0111, 0, 0); chk("prio3", {26'd0, stall}, 32'h0f); tick("p3");
    set(4'b1111, 0, 0); chk("prio4", {26'd0, stall}, 32'h1f); tick("p4");
    // Plain exception then ERET
    set(4'b0000, 32'h8, 32'h0);
    chk("exc.flush", {31'd0, flush}, 32'd1);
    chk("exc.pc", new_pc, 32'h40);
    tick("exc");
    set(4'b0000, 0, 0); tick("exc_rec");
    set(4'b0000, 32'he, 32'h0040_1230);
    chk("eret.pc", new_pc, 32'h0040_1230);
    tick("eret");
    set(4'b0000, 0, 0); tick("eret_rec");
    // Held exception behind a stalled EX/MEM register
    set(4'b1000, 32'h8, 0);
    chk("held0.flush", {31'd0, flush}, 32'd1); chk("held0.stall", {26'd0, stall}, 32'h00); tick("h0");
    chk("held1.flush", {31'd0, flush}, 32'd0); chk("held1.stall", {26'd0, stall}, 32'h1f); tick("h1");
    chk("held2.flush", {31'd0, flush}, 32'd1); chk("held2.stall", {26'd0, stall}, 32'h00); tick("h2");
    set(4'b0000, 0, 0); tick("h_rec");
    // Watchdog with limit 4
    do_reset();
    set(4'b0010, 0, 0);
    for (int i = 0; i < 3; i++) tick("wd_a");
    set(4'b0000, 0, 0);
    chk("wd.short", {31'd0, timeout}, 32'd0);
    tick("wd_idle");
    set(4'b0010, 0, 0);
    for (int i = 0; i < 4; i++) tick("wd_b");
    set(4'b0000, 0, 0);
    chk("wd.fire", {31'd0, timeout}, 32'd1);
    tick("wd_c");
    chk("wd.sticky", {31'd0, timeout}, 32'd1);
    // Stall-cycle counter
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set(4'b0001, 0, 0);
      for (int i = 0; i < 5; i++) tick("cnt_s");
      set(4'b0000, 0, 0);
      tick("cnt_i");
    end
    chk("cnt.ten", stall_cycles, 32'd10);
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    m_sc = 64'hFFFF_FFFD;
    set(4'b0100, 0, 0);
    for (int i = 0; i < 5; i++) tick("cnt_sat");
    chk("cnt.sat", stall_cycles, 32'hFFFF_FFFF);
    // Asynchronous reset in the middle of a flush
    set(4'b0001, 32'h8, 0);
    chk("ar.pre_flush", {31'd0, flush}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ar.flush",   {31'd0, flush}, 32'd0);
    chk("ar.stall",   {26'd0, stall}, 32'd0);
    chk("ar.new_pc",  new_pc, 32'd0);
    chk("ar.timeout", {31'd0, timeout}, 32'd0);
    chk("ar.cycles",  stall_cycles, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    set(4'b0001, 32'h8, 0);
    chk("ar.run_flush", {31'd0, flush}, 32'd1);
    tick("ar_post");
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      r_exc = ($urandom_range(0, 4) != 0) ? 32'd0 :
              ($urandom_range(0, 1) == 0) ? 32'he : 32'($urandom_range(1, 20));
      set(r_req, r_exc, $urandom);
      tick("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
